// File: rtl/gain_cfg_ctrl_if.sv
// ----------------------------------------------------------------------------
// gain_cfg_ctrl_if
// Bundles the command byte stream and the gain register bank write port of
// gain_cfg_ctrl.
//   rx_valid / rx_data / rx_ready : byte stream, transfer on valid && ready
//   wr_en / wr_addr / wr_data     : single-cycle write strobe to the gain bank
//   busy / cmd_done / err         : status (frame active, frame done, frame bad)
// Modports:
//   master : the command source / bank owner (testbench or upstream logic)
//   slave  : the gain_cfg_ctrl parser itself
// ----------------------------------------------------------------------------
interface gain_cfg_ctrl_if #(
  parameter int GAIN_WIDTH = 13
);
  logic                  rx_valid;
  logic [7:0]            rx_data;
  logic                  rx_ready;
  logic                  wr_en;
  logic [7:0]            wr_addr;
  logic [GAIN_WIDTH-1:0] wr_data;
  logic                  busy;
  logic                  cmd_done;
  logic                  err;

  modport master (
    output rx_valid, rx_data,
    input  rx_ready, wr_en, wr_addr, wr_data, busy, cmd_done, err
  );

  modport slave (
    input  rx_valid, rx_data,
    output rx_ready, wr_en, wr_addr, wr_data, busy, cmd_done, err
  );
endinterface

// File: rtl/gain_cfg_ctrl.sv
// ----------------------------------------------------------------------------
// gain_cfg_ctrl
// Parses 3-byte gain commands and sequences writes into the equalizer's
// per-band gain register bank.
//   byte0 : [7:4] sync 4'hA, [3:0] band index (4'hF = broadcast to all bands)
//   byte1 : gain[GAIN_WIDTH-1:8] in the low bits, remaining bits must be 0
//   byte2 : gain[7:0]
// Parameters:
//   GAIN_WIDTH : gain word width, Q5.8 unsigned, legal range 9..16
//   NUM_BANDS  : number of gain registers, legal range 1..15
//   TIMEOUT    : idle cycles allowed between bytes of one frame, >= 1
// Ports:
//   clk : system clock, rising edge
//   rst : synchronous active-low reset
//   bus : gain_cfg_ctrl_if.slave (byte stream in, write strobe and status out)
// ----------------------------------------------------------------------------
module gain_cfg_ctrl #(
  parameter int GAIN_WIDTH = 13,
  parameter int NUM_BANDS  = 10,
  parameter int TIMEOUT    = 255
) (
  input  logic clk,
  input  logic rst,
  gain_cfg_ctrl_if.slave bus
);

  localparam int HI_W  = GAIN_WIDTH - 8;
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  // Last idle count before the abort fires; the counter never holds TIMEOUT.
  localparam logic [CNT_W-1:0] TO_LAST   = CNT_W'(TIMEOUT - 1);
  localparam logic [7:0]       LAST_BAND = 8'(NUM_BANDS - 1);
  localparam logic [3:0]       NB4       = 4'(NUM_BANDS);
  // Bits of byte1 above the gain high field; any one set rejects the frame.
  localparam logic [7:0]       RSV_MASK  = 8'(16'h00FF << HI_W);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_GET_HI = 3'd1,
    ST_GET_LO = 3'd2,
    ST_WRITE  = 3'd3,
    ST_BCAST  = 3'd4
  } state_t;

  state_t                state_r;
  state_t                state_s;
  logic [CNT_W-1:0]      cnt_r;
  logic [3:0]            idx_r;
  logic                  bcast_r;
  logic [HI_W-1:0]       hi_r;
  logic [7:0]            wr_addr_r;
  logic [GAIN_WIDTH-1:0] wr_data_r;
  logic                  err_r;

  logic rx_ready_s;
  logic accept_s;
  logic hdr_sync_s;
  logic hdr_single_s;
  logic hdr_bcast_s;
  logic hdr_ok_s;
  logic rsv_bad_s;
  logic in_frame_s;
  logic timeout_s;
  logic bcast_last_s;
  logic err_event_s;
  logic wr_en_s;
  logic cmd_done_s;
  logic busy_s;

  // Frame decode: acceptance, header/byte1 legality and inter-byte timeout.
  always_comb begin
    rx_ready_s   = 1'b0;
    in_frame_s   = 1'b0;
    if (rst && (state_r == ST_IDLE || state_r == ST_GET_HI || state_r == ST_GET_LO)) begin
      rx_ready_s = 1'b1;
    end else begin
      rx_ready_s = 1'b0;
    end
    if (state_r == ST_GET_HI || state_r == ST_GET_LO) begin
      in_frame_s = 1'b1;
    end else begin
      in_frame_s = 1'b0;
    end
    accept_s     = bus.rx_valid & rx_ready_s;
    hdr_sync_s   = (bus.rx_data[7:4] == 4'hA);
    hdr_single_s = (bus.rx_data[3:0] < NB4);
    hdr_bcast_s  = (bus.rx_data[3:0] == 4'hF);
    hdr_ok_s     = hdr_sync_s & (hdr_single_s | hdr_bcast_s);
    rsv_bad_s    = |(bus.rx_data & RSV_MASK);
    timeout_s    = in_frame_s & ~accept_s & (cnt_r == TO_LAST);
    bcast_last_s = (wr_addr_r == LAST_BAND);
    err_event_s  = ((state_r == ST_IDLE) & accept_s & ~hdr_ok_s)
                 | ((state_r == ST_GET_HI) & accept_s & rsv_bad_s)
                 | timeout_s;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_s && hdr_ok_s) begin
          state_s = ST_GET_HI;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_GET_HI: begin
        if (accept_s) begin
          state_s = rsv_bad_s ? ST_IDLE : ST_GET_LO;
        end else if (timeout_s) begin
          state_s = ST_IDLE;
        end else begin
          state_s = ST_GET_HI;
        end
      end
      ST_GET_LO: begin
        if (accept_s) begin
          state_s = bcast_r ? ST_BCAST : ST_WRITE;
        end else if (timeout_s) begin
          state_s = ST_IDLE;
        end else begin
          state_s = ST_GET_LO;
        end
      end
      ST_WRITE: begin
        state_s = ST_IDLE;
      end
      ST_BCAST: begin
        if (bcast_last_s) begin
          state_s = ST_IDLE;
        end else begin
          state_s = ST_BCAST;
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // Datapath: timeout counter, frame assembly, write address/data, err pulse.
  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_r     <= {CNT_W{1'b0}};
      idx_r     <= 4'd0;
      bcast_r   <= 1'b0;
      hi_r      <= {HI_W{1'b0}};
      wr_addr_r <= 8'd0;
      wr_data_r <= {GAIN_WIDTH{1'b0}};
      err_r     <= 1'b0;
    end else begin
      err_r <= err_event_s;

      // Counts only idle cycles inside a frame; any accept or abort restarts it.
      if (in_frame_s && !accept_s && !timeout_s) begin
        cnt_r <= cnt_r + CNT_W'(1);
      end else begin
        cnt_r <= {CNT_W{1'b0}};
      end

      if (state_r == ST_IDLE && accept_s && hdr_ok_s) begin
        idx_r   <= bus.rx_data[3:0];
        bcast_r <= hdr_bcast_s;
      end

      if (state_r == ST_GET_HI && accept_s && !rsv_bad_s) begin
        hi_r <= bus.rx_data[HI_W-1:0];
      end

      // Address/data are loaded on the byte2 edge so they are valid in the
      // very first write cycle; broadcast then walks the address upward.
      if (state_r == ST_GET_LO && accept_s) begin
        wr_data_r <= {hi_r, bus.rx_data};
        wr_addr_r <= bcast_r ? 8'd0 : {4'd0, idx_r};
      end else if (state_r == ST_BCAST && !bcast_last_s) begin
        wr_addr_r <= wr_addr_r + 8'd1;
      end
    end
  end

  // Output decode from the registered state.
  always_comb begin
    wr_en_s    = 1'b0;
    cmd_done_s = 1'b0;
    case (state_r)
      ST_WRITE: begin
        wr_en_s    = 1'b1;
        cmd_done_s = 1'b1;
      end
      ST_BCAST: begin
        wr_en_s    = 1'b1;
        cmd_done_s = bcast_last_s;
      end
      default: begin
        wr_en_s    = 1'b0;
        cmd_done_s = 1'b0;
      end
    endcase
    if (rst && state_r != ST_IDLE) begin
      busy_s = 1'b1;
    end else begin
      busy_s = 1'b0;
    end
  end

  assign bus.rx_ready = rx_ready_s;
  assign bus.wr_en    = wr_en_s;
  assign bus.wr_addr  = wr_addr_r;
  assign bus.wr_data  = wr_data_r;
  assign bus.busy     = busy_s;
  assign bus.cmd_done = cmd_done_s;
  assign bus.err      = err_r;

endmodule

// File: tb/tb_gain_cfg_ctrl.sv
// ----------------------------------------------------------------------------
// tb_gain_cfg_ctrl
// Directed self-checking bench for gain_cfg_ctrl (GAIN_WIDTH=13, NUM_BANDS=10,
// TIMEOUT=4). Inputs change and outputs are sampled 1 time unit after each
// rising clock edge.
// ----------------------------------------------------------------------------
module tb_gain_cfg_ctrl;

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  int   wr_count;

  gain_cfg_ctrl_if #(.GAIN_WIDTH(13)) bus ();

  gain_cfg_ctrl #(
    .GAIN_WIDTH(13),
    .NUM_BANDS (10),
    .TIMEOUT   (4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Counts every write strobe seen, to catch lost or duplicated writes.
  always @(negedge clk) begin
    if (bus.wr_en === 1'b1) wr_count <= wr_count + 1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents a byte and returns 1 unit after the edge that accepts it.
  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    bus.rx_valid = 1'b1;
    bus.rx_data  = b;
    while (bus.rx_ready !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    if (n >= 40) begin
      checks++; errors++;
      $display("FAIL send_byte_wait: rx_ready=%b after 40 cycles, required 1", bus.rx_ready);
    end
    tick();
  endtask

  task automatic send_frame(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
    send_byte(b0);
    send_byte(b1);
    send_byte(b2);
  endtask

  task automatic test_reset();
    rst = 1'b0;
    bus.rx_valid = 1'b1;
    bus.rx_data  = 8'hA3;
    tick(); tick(); tick();
    checks++; if (bus.rx_ready !== 1'b0) begin errors++; $display("FAIL reset_rx_ready: got %b want 0", bus.rx_ready); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
    checks++; if (bus.wr_en !== 1'b0 || bus.cmd_done !== 1'b0 || bus.err !== 1'b0) begin
      errors++; $display("FAIL reset_pulses: wr_en=%b cmd_done=%b err=%b want 000", bus.wr_en, bus.cmd_done, bus.err); end
    checks++; if (bus.wr_addr !== 8'd0 || bus.wr_data !== 13'd0) begin
      errors++; $display("FAIL reset_wr_bus: addr=%h data=%h want 00 0000", bus.wr_addr, bus.wr_data); end
    bus.rx_valid = 1'b0;
    rst = 1'b1;
    tick();
    checks++; if (bus.rx_ready !== 1'b1 || bus.busy !== 1'b0) begin
      errors++; $display("FAIL reset_release: rx_ready=%b busy=%b want 1 0", bus.rx_ready, bus.busy); end
  endtask

  task automatic test_single();
    send_byte(8'hA3);
    checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL single_busy_hdr: got %b want 1", bus.busy); end
    send_byte(8'h01);
    send_byte(8'h00);
    bus.rx_valid = 1'b0;
    checks++; if (bus.wr_en !== 1'b1 || bus.cmd_done !== 1'b1 || bus.err !== 1'b0) begin
      errors++; $display("FAIL single_strobe: wr_en=%b cmd_done=%b err=%b want 1 1 0", bus.wr_en, bus.cmd_done, bus.err); end
    checks++; if (bus.wr_addr !== 8'd3 || bus.wr_data !== 13'h0100) begin
      errors++; $display("FAIL single_addr_data: addr=%h data=%h want 03 0100", bus.wr_addr, bus.wr_data); end
    checks++; if (bus.rx_ready !== 1'b0) begin errors++; $display("FAIL single_rx_ready: got %b want 0", bus.rx_ready); end
    tick();
    checks++; if (bus.wr_en !== 1'b0 || bus.busy !== 1'b0 || bus.cmd_done !== 1'b0) begin
      errors++; $display("FAIL single_after: wr_en=%b busy=%b cmd_done=%b want 000", bus.wr_en, bus.busy, bus.cmd_done); end
  endtask

  task automatic test_bcast();
    send_frame(8'hAF, 8'h1F, 8'hFF);
    bus.rx_valid = 1'b0;
    for (int i = 0; i < 10; i++) begin
      checks++;
      if (bus.wr_en !== 1'b1 || bus.wr_addr !== 8'(i) || bus.wr_data !== 13'h1FFF ||
          bus.cmd_done !== (i == 9) || bus.rx_ready !== 1'b0 || bus.err !== 1'b0) begin
        errors++;
        $display("FAIL bcast_cycle%0d: wr_en=%b addr=%h data=%h cmd_done=%b rx_ready=%b err=%b want 1 %h 1fff %b 0 0",
                 i, bus.wr_en, bus.wr_addr, bus.wr_data, bus.cmd_done, bus.rx_ready, bus.err, 8'(i), (i == 9));
      end
      tick();
    end
    checks++; if (bus.wr_en !== 1'b0 || bus.busy !== 1'b0) begin
      errors++; $display("FAIL bcast_end: wr_en=%b busy=%b want 0 0", bus.wr_en, bus.busy); end
  endtask

  task automatic test_errors();
    logic [7:0] hdrs [2];
    int         w0;
    hdrs[0] = 8'h53;
    hdrs[1] = 8'hAC;
    for (int k = 0; k < 3; k++) begin
      w0 = wr_count;
      if (k < 2) begin
        send_byte(hdrs[k]);
      end else begin
        send_byte(8'hA2);
        send_byte(8'h20);
      end
      bus.rx_valid = 1'b0;
      checks++; if (bus.err !== 1'b1 || bus.busy !== 1'b0 || bus.wr_en !== 1'b0 || bus.cmd_done !== 1'b0) begin
        errors++; $display("FAIL err_case%0d_pulse: err=%b busy=%b wr_en=%b cmd_done=%b want 1 0 0 0",
                           k, bus.err, bus.busy, bus.wr_en, bus.cmd_done); end
      tick();
      checks++; if (bus.err !== 1'b0 || bus.busy !== 1'b0 || wr_count != w0) begin
        errors++; $display("FAIL err_case%0d_after: err=%b busy=%b writes=%0d want 0 0 0",
                           k, bus.err, bus.busy, wr_count - w0); end
      send_frame(8'hA2, 8'h00, 8'h80);
      bus.rx_valid = 1'b0;
      checks++; if (bus.wr_en !== 1'b1 || bus.wr_addr !== 8'd2 || bus.wr_data !== 13'h0080 || bus.cmd_done !== 1'b1) begin
        errors++; $display("FAIL err_case%0d_recover: wr_en=%b addr=%h data=%h cmd_done=%b want 1 02 0080 1",
                           k, bus.wr_en, bus.wr_addr, bus.wr_data, bus.cmd_done); end
      tick();
    end
  endtask

  task automatic test_timeout();
    send_byte(8'hA1);
    bus.rx_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (bus.err !== 1'b0 || bus.busy !== 1'b1) begin
        errors++; $display("FAIL timeout_gap%0d: err=%b busy=%b want 0 1", i, bus.err, bus.busy); end
    end
    tick();
    checks++; if (bus.err !== 1'b1 || bus.busy !== 1'b0 || bus.wr_en !== 1'b0) begin
      errors++; $display("FAIL timeout_abort: err=%b busy=%b wr_en=%b want 1 0 0", bus.err, bus.busy, bus.wr_en); end
    tick();
    checks++; if (bus.err !== 1'b0) begin errors++; $display("FAIL timeout_pulse_len: err=%b want 0", bus.err); end
    // Same frame with 3-cycle gaps between bytes must survive.
    send_byte(8'hA1);
    bus.rx_valid = 1'b0;
    tick(); tick(); tick();
    send_byte(8'h00);
    bus.rx_valid = 1'b0;
    tick(); tick(); tick();
    checks++; if (bus.err !== 1'b0 || bus.busy !== 1'b1) begin
      errors++; $display("FAIL timeout_gap_ok: err=%b busy=%b want 0 1", bus.err, bus.busy); end
    send_byte(8'h40);
    bus.rx_valid = 1'b0;
    checks++; if (bus.wr_en !== 1'b1 || bus.wr_addr !== 8'd1 || bus.wr_data !== 13'h0040 || bus.err !== 1'b0) begin
      errors++; $display("FAIL timeout_write: wr_en=%b addr=%h data=%h err=%b want 1 01 0040 0",
                         bus.wr_en, bus.wr_addr, bus.wr_data, bus.err); end
    tick();
  endtask

  task automatic test_reset_bcast();
    int w0;
    send_frame(8'hAF, 8'h00, 8'h07);
    bus.rx_valid = 1'b0;
    tick(); tick(); tick(); tick();
    checks++; if (bus.wr_en !== 1'b1 || bus.wr_addr !== 8'd4) begin
      errors++; $display("FAIL rstb_fifth: wr_en=%b addr=%h want 1 04", bus.wr_en, bus.wr_addr); end
    rst = 1'b0;
    #1;
    checks++; if (bus.busy !== 1'b0 || bus.rx_ready !== 1'b0) begin
      errors++; $display("FAIL rstb_forced: busy=%b rx_ready=%b want 0 0", bus.busy, bus.rx_ready); end
    tick();
    w0 = wr_count;
    checks++; if (bus.wr_en !== 1'b0 || bus.cmd_done !== 1'b0 || bus.err !== 1'b0 ||
                  bus.wr_addr !== 8'd0 || bus.wr_data !== 13'd0 || bus.busy !== 1'b0) begin
      errors++; $display("FAIL rstb_edge: wr_en=%b cmd_done=%b err=%b addr=%h data=%h busy=%b want 0 0 0 00 0000 0",
                         bus.wr_en, bus.cmd_done, bus.err, bus.wr_addr, bus.wr_data, bus.busy); end
    tick();
    rst = 1'b1;
    tick(); tick();
    checks++; if (wr_count != w0 || bus.busy !== 1'b0) begin
      errors++; $display("FAIL rstb_no_resume: writes=%0d busy=%b want 0 0", wr_count - w0, bus.busy); end
    send_frame(8'hA0, 8'h00, 8'h01);
    bus.rx_valid = 1'b0;
    checks++; if (bus.wr_en !== 1'b1 || bus.wr_addr !== 8'd0 || bus.wr_data !== 13'h0001 || bus.cmd_done !== 1'b1) begin
      errors++; $display("FAIL rstb_recover: wr_en=%b addr=%h data=%h cmd_done=%b want 1 00 0001 1",
                         bus.wr_en, bus.wr_addr, bus.wr_data, bus.cmd_done); end
    tick();
  endtask

  task automatic test_back_to_back();
    int w0;
    w0 = wr_count;
    send_frame(8'hA4, 8'h00, 8'h10);
    checks++; if (bus.wr_en !== 1'b1 || bus.wr_addr !== 8'd4 || bus.wr_data !== 13'h0010) begin
      errors++; $display("FAIL b2b_first: wr_en=%b addr=%h data=%h want 1 04 0010", bus.wr_en, bus.wr_addr, bus.wr_data); end
    // Next header is held on the bus through the WRITE cycle.
    bus.rx_data = 8'hA5;
    tick();
    checks++; if (bus.rx_ready !== 1'b1 || bus.busy !== 1'b0 || bus.wr_en !== 1'b0) begin
      errors++; $display("FAIL b2b_idle: rx_ready=%b busy=%b wr_en=%b want 1 0 0", bus.rx_ready, bus.busy, bus.wr_en); end
    tick();
    checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL b2b_hdr_taken: busy=%b want 1", bus.busy); end
    send_byte(8'h00);
    send_byte(8'h20);
    bus.rx_valid = 1'b0;
    checks++; if (bus.wr_en !== 1'b1 || bus.wr_addr !== 8'd5 || bus.wr_data !== 13'h0020 || bus.cmd_done !== 1'b1) begin
      errors++; $display("FAIL b2b_second: wr_en=%b addr=%h data=%h cmd_done=%b want 1 05 0020 1",
                         bus.wr_en, bus.wr_addr, bus.wr_data, bus.cmd_done); end
    tick();
    tick();
    checks++; if (wr_count - w0 != 2 || bus.busy !== 1'b0) begin
      errors++; $display("FAIL b2b_count: writes=%0d busy=%b want 2 0", wr_count - w0, bus.busy); end
  endtask

  initial begin
    checks       = 0;
    errors       = 0;
    wr_count     = 0;
    rst          = 1'b0;
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;
    test_reset();
    test_single();
    test_bcast();
    test_errors();
    test_timeout();
    test_reset_bcast();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/gain_cfg_ctrl.md
Name: gain_cfg_ctrl

Overview:
Byte-stream command parser and write sequencer that configures the equalizer's per-band gain register bank.
- Accepts 3-byte frames on a valid/ready byte interface and assembles a full GAIN_WIDTH-bit Q5.8 gain.
- Issues single-cycle write strobes (wr_en/wr_addr/wr_data) to the gain register bank.
- Supports single-band writes and a broadcast write to all bands.
- Rejects malformed frames and aborts stalled frames.

Parameters:
GAIN_WIDTH, 13, gain word width (Q5.8); must be 9..16.
NUM_BANDS, 10, number of gain registers; must be 1..15.
TIMEOUT, 255, max idle cycles between bytes inside a frame before abort; >= 1.

Ports:
clk  in  1  single system clock; all logic on rising edge.
rst  in  1  synchronous, active-low reset.
rx_valid  in  1  byte on rx_data is valid.
rx_data  in  8  incoming command byte.
rx_ready  out  1  parser can accept a byte; transfer occurs when rx_valid && rx_ready at a rising edge.
wr_en  out  1  write strobe to the gain register bank, one cycle per register.
wr_addr  out  8  band index for the write (0..NUM_BANDS-1).
wr_data  out  GAIN_WIDTH  gain value for the write.
busy  out  1  frame in progress or write sequence active.
cmd_done  out  1  one-cycle pulse, coincident with the last wr_en of a valid frame.
err  out  1  one-cycle pulse on a rejected or aborted frame.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-low. While rst=0 at a rising edge:
  - FSM goes to IDLE; timeout counter, assembly registers, wr_addr and wr_data clear to 0.
  - wr_en, cmd_done and err are 0. rx_ready and busy are forced to 0 while rst=0.
  - Reset mid-frame or mid-broadcast discards the partial frame; no further writes are issued.
- Frame format:
  - byte0 = header: [7:4] sync nibble, must be 4'hA; [3:0] band index.
  - byte1 = gain high: [GAIN_WIDTH-9:0] carries gain[GAIN_WIDTH-1:8]; all remaining upper bits must be 0.
  - byte2 = gain low: gain[7:0].
- FSM states: IDLE, GET_HI, GET_LO, WRITE, BCAST.
  - rx_ready=1 in IDLE, GET_HI and GET_LO; 0 in WRITE and BCAST.
  - busy=1 in every state except IDLE.
- IDLE: on byte accept:
  - sync != 4'hA -> err pulse next cycle, stay IDLE.
  - band index < NUM_BANDS -> latch index, go to GET_HI.
  - band index == 4'hF -> broadcast flag set, go to GET_HI.
  - any other index -> err pulse, stay IDLE.
- GET_HI: on accept:
  - any nonzero reserved upper bit -> err pulse, go to IDLE, no write.
  - otherwise latch the high bits, go to GET_LO.
- GET_LO: on accept, latch the low byte; go to WRITE (single) or BCAST (broadcast).
- WRITE: exactly one cycle.
  - wr_en=1, wr_addr=latched index, wr_data=assembled gain, cmd_done=1.
  - Next state IDLE.
  - Latency: wr_en is asserted in the cycle immediately after the byte2 accept edge.
- BCAST: NUM_BANDS consecutive cycles.
  - wr_en=1 throughout; wr_addr steps 0,1,...,NUM_BANDS-1; wr_data constant.
  - cmd_done=1 only with wr_addr=NUM_BANDS-1; then go to IDLE.
- Outputs outside write cycles:
  - wr_en=0. wr_addr and wr_data hold their last values (do not care when wr_en=0).
  - cmd_done is 0 except on the final write.
  - err and cmd_done are never asserted in the same cycle.
- Timeout:
  - In GET_HI and GET_LO, the counter increments each cycle without an accept and clears on every accept.
  - When it reaches TIMEOUT: err pulse, go to IDLE, no write.
  - The counter is held at 0 in IDLE, WRITE and BCAST.
- rx_valid while rx_ready=0: the byte is not consumed; the source must hold it, and it is accepted in the first IDLE cycle.
- Back-to-back frames: the next header can be accepted in the IDLE cycle right after WRITE or the last BCAST cycle. There is no dead cycle beyond WRITE/BCAST.
- Gain values: wr_data is passed through unmodified (Q5.8, unsigned); there is no saturation or range change.

Test Plan:
- Reset then frame A3,01,00 with rx_valid held -> single wr_en one cycle after byte2 accept, wr_addr=3, wr_data=0x0100, cmd_done coincident, busy low the next cycle.
- Broadcast AF,1F,FF -> 10 consecutive wr_en cycles with wr_addr 0..9, wr_data=0x1FFF each, cmd_done only at addr 9, rx_ready=0 throughout.
- Error frames: header 53 -> err pulse, no write; header AC (index 12) -> err pulse; A2,20,xx -> err after byte1, no write, and byte 0x20 not treated as a header. Each is followed by a valid A2,00,80 -> wr_data=0x0080 to addr 2.
- Timeout with TIMEOUT=4: send A1, then idle 4 cycles -> err pulse, FSM IDLE. Then A1,00,40 -> normal write to addr 1; an idle gap of 3 cycles between bytes gives no error.
- Reset mid-broadcast: assert rst during the 5th BCAST cycle -> no wr_en after the reset edge, all outputs 0; after release, frame A0,00,01 writes addr 0 correctly.
- Backpressure: rx_valid held high with frame A4,00,10 immediately followed by A5,00,20 -> writes addr 4=0x0010 then addr 5=0x0020; second header accepted in the IDLE cycle after WRITE, no byte lost or duplicated.
